// File: rtl/vx_mem_bridge_pkg.sv
// Shared types and width constants for the Vortex memory-bus endpoint.
// Widths follow the VX_MEM_* defines when present, otherwise the Vortex defaults.

`ifndef VX_MEM_DATA_WIDTH
`define VX_MEM_DATA_WIDTH 512
`endif
`ifndef VX_MEM_BYTEEN_WIDTH
`define VX_MEM_BYTEEN_WIDTH (`VX_MEM_DATA_WIDTH / 8)
`endif
`ifndef VX_MEM_ADDR_WIDTH
`define VX_MEM_ADDR_WIDTH 26
`endif
`ifndef VX_MEM_TAG_WIDTH
`define VX_MEM_TAG_WIDTH 8
`endif

package vx_mem_bridge_pkg;

    localparam int unsigned MEM_DATA_W   = `VX_MEM_DATA_WIDTH;
    localparam int unsigned MEM_BYTEEN_W = `VX_MEM_BYTEEN_WIDTH;
    localparam int unsigned MEM_ADDR_W   = `VX_MEM_ADDR_WIDTH;
    localparam int unsigned MEM_TAG_W    = `VX_MEM_TAG_WIDTH;

    // Pattern returned for reads that fall outside the RAM.
    localparam logic [MEM_DATA_W-1:0] OOB_DATA_DEFAULT = {(MEM_DATA_W / 32){32'hDEADBEEF}};

    typedef struct packed {
        logic [MEM_DATA_W-1:0] data;
        logic [MEM_TAG_W-1:0]  tag;
    } rsp_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [MEM_DATA_W-1:0] data;
        logic [MEM_TAG_W-1:0]  tag;
    } pipe_stage_t;

endpackage

// File: rtl/vx_mem_rsp_fifo.sv
// Response FIFO for the memory bridge. Pointers carry one extra wrap bit so
// full and empty are distinguishable; DEPTH must be a power of two >= 2.

module vx_mem_rsp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign count = CNT_W'(wr_ptr_q - rd_ptr_q);
    // Head reads as zero when empty so the bus idles at a known value.
    assign head  = empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];

    // Storage write; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    push_not_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
    pop_not_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/vx_mem_bridge.sv
// Memory endpoint for the Vortex external memory bus: word-addressed RAM,
// fixed-latency in-order read pipeline and a credit-limited response FIFO.
// Credits cover reads in the pipeline plus FIFO entries, so the FIFO can
// never overflow and no response is ever dropped.

module vx_mem_bridge
    import vx_mem_bridge_pkg::*;
#(
    parameter int unsigned       DATA_W    = MEM_DATA_W,
    parameter int unsigned       BYTEEN_W  = DATA_W / 8,
    parameter int unsigned       ADDR_W    = MEM_ADDR_W,
    parameter int unsigned       TAG_W     = MEM_TAG_W,
    parameter int unsigned       DEPTH     = 64,
    parameter int unsigned       LATENCY   = 4,
    parameter int unsigned       RSP_DEPTH = 4,
    parameter logic [DATA_W-1:0] OOB_DATA  = OOB_DATA_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_req_valid,
    input  logic                mem_req_rw,
    input  logic [BYTEEN_W-1:0] mem_req_byteen,
    input  logic [ADDR_W-1:0]   mem_req_addr,
    input  logic [DATA_W-1:0]   mem_req_data,
    input  logic [TAG_W-1:0]    mem_req_tag,
    output logic                mem_req_ready,
    output logic                mem_rsp_valid,
    output logic [DATA_W-1:0]   mem_rsp_data,
    output logic [TAG_W-1:0]    mem_rsp_tag,
    input  logic                mem_rsp_ready,
    output logic                busy,
    output logic                oob_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CRD_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned ENT_W = $bits(rsp_entry_t);

    logic [DATA_W-1:0] ram_q [DEPTH];
    pipe_stage_t       pipe_q [LATENCY];
    logic [CRD_W-1:0]  credit_q;
    logic [CRD_W-1:0]  credit_d;
    logic              oob_err_q;

    logic              rd_fire;
    logic              wr_fire;
    logic              rsp_pop;
    logic              addr_oob;
    logic [IDX_W-1:0]  req_idx;
    logic [DATA_W-1:0] rd_line;

    rsp_entry_t        push_entry;
    rsp_entry_t        head_entry;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CRD_W-1:0]  fifo_count;
    int                pipe_cnt;

    // Ready depends only on registered credit state, never on mem_req_valid.
    assign mem_req_ready = !reset && (credit_q < CRD_W'(RSP_DEPTH));
    assign rd_fire       = mem_req_valid && mem_req_ready && !mem_req_rw;
    assign wr_fire       = mem_req_valid && mem_req_ready && mem_req_rw;
    assign rsp_pop       = mem_rsp_valid && mem_rsp_ready;

    assign addr_oob = (mem_req_addr >= ADDR_W'(DEPTH));
    assign req_idx  = mem_req_addr[IDX_W-1:0];
    // Read data is the pre-edge RAM content, so a same-edge write cannot leak in.
    assign rd_line  = addr_oob ? OOB_DATA : ram_q[req_idx];

    // RAM: byte-masked writes for in-bounds addresses; cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ram_q[i] <= '0;
            end
        end else if (wr_fire && !addr_oob) begin
            for (int unsigned b = 0; b < BYTEEN_W; b++) begin
                if (mem_req_byteen[b]) begin
                    ram_q[req_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures at the accept edge, last stage feeds the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: rd_fire, data: rd_line, tag: mem_req_tag};
            for (int unsigned k = 1; k < LATENCY; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign push_entry = '{data: pipe_q[LATENCY-1].data, tag: pipe_q[LATENCY-1].tag};

    vx_mem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (ENT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_q[LATENCY-1].valid),
        .push_data (push_entry),
        .pop       (rsp_pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign mem_rsp_valid = !fifo_empty;
    assign mem_rsp_data  = head_entry.data;
    assign mem_rsp_tag   = head_entry.tag;

    // Credit next state: read accept takes one, response pop returns one.
    always_comb begin
        credit_d = credit_q;
        case ({rd_fire, rsp_pop})
            2'b10:   credit_d = credit_q + CRD_W'(1);
            2'b01:   credit_d = credit_q - CRD_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    // Credit counter and sticky out-of-bounds flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_q  <= '0;
            oob_err_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
            if (mem_req_valid && mem_req_ready && addr_oob) begin
                oob_err_q <= 1'b1;
            end
        end
    end

    assign busy    = (credit_q != '0);
    assign oob_err = oob_err_q;

    // Reads currently travelling through the pipeline.
    always_comb begin
        pipe_cnt = 0;
        for (int unsigned k = 0; k < LATENCY; k++) begin
            pipe_cnt += int'(pipe_q[k].valid);
        end
    end

    credit_tracks_outstanding: assert property (@(posedge clk) disable iff (reset)
        int'(credit_q) == pipe_cnt + int'(fifo_count));
    full_only_at_limit: assert property (@(posedge clk) disable iff (reset)
        fifo_full |-> (credit_q == CRD_W'(RSP_DEPTH)));

endmodule

// File: tb/tb_vx_mem_bridge.sv
// Scoreboard bench for vx_mem_bridge: a queue-and-array reference model is
// updated at every accepted request; a negedge monitor checks every response,
// handshake and status output against it.

module tb_vx_mem_bridge;

    localparam int DW    = 512;
    localparam int BW    = 64;
    localparam int AW    = 26;
    localparam int TW    = 8;
    localparam int DEPTH = 64;
    localparam int LAT   = 4;
    localparam int RD    = 4;
    localparam logic [DW-1:0] OOB = {16{32'hDEADBEEF}};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req_valid = 1'b0;
    logic          mem_req_rw = 1'b0;
    logic [BW-1:0] mem_req_byteen = '0;
    logic [AW-1:0] mem_req_addr = '0;
    logic [DW-1:0] mem_req_data = '0;
    logic [TW-1:0] mem_req_tag = '0;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic          mem_rsp_ready = 1'b0;
    logic          busy;
    logic          oob_err;

    always #5 clk = ~clk;

    vx_mem_bridge #(
        .DATA_W    (DW),
        .BYTEEN_W  (BW),
        .ADDR_W    (AW),
        .TAG_W     (TW),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .RSP_DEPTH (RD),
        .OOB_DATA  (OOB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready),
        .busy           (busy),
        .oob_err        (oob_err)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            acc;
        bit            exact;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_ram [DEPTH];
    bit            model_oob = 1'b0;
    int            cyc = 0;
    int            compared = 0;
    int            mismatched = 0;
    bit            head_seen = 1'b0;
    int            rd_accepts = 0;
    int            pop_cyc[$];
    int            pop_tag[$];
    int            rdy_mode = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Consumer: 0 = stall, 1 = always ready, otherwise random.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       mem_rsp_ready = 1'b0;
            1:       mem_rsp_ready = 1'b1;
            default: mem_rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: status check first (state after the last edge), then the
    // response and request handshakes that will fire at the next edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_oob = 1'b0;
            head_seen = 1'b0;
            for (int i = 0; i < DEPTH; i++) model_ram[i] = '0;
            chk("rst_req_ready", DW'(mem_req_ready), '0);
            chk("rst_rsp_valid", DW'(mem_rsp_valid), '0);
            chk("rst_rsp_data", mem_rsp_data, '0);
            chk("rst_busy", DW'(busy), '0);
            chk("rst_oob_err", DW'(oob_err), '0);
        end else begin
            chk("req_ready", DW'(mem_req_ready), DW'(exp_q.size() < RD));
            chk("busy", DW'(busy), DW'(exp_q.size() != 0));
            chk("oob_err", DW'(oob_err), DW'(model_oob));
            if (mem_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rsp: got tag %h, required no response", mem_rsp_tag);
                end else begin
                    chk("rsp_data", mem_rsp_data, exp_q[0].data);
                    chk("rsp_tag", DW'(mem_rsp_tag), DW'(exp_q[0].tag));
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        if (exp_q[0].exact) begin
                            chk_int("rsp_latency", cyc - exp_q[0].acc, LAT);
                        end else begin
                            compared++;
                            if (cyc - exp_q[0].acc < LAT) begin
                                mismatched++;
                                $display("FAIL rsp_early: got latency %0d required >= %0d",
                                         cyc - exp_q[0].acc, LAT);
                            end
                        end
                    end
                    if (mem_rsp_ready) begin
                        pop_cyc.push_back(cyc);
                        pop_tag.push_back(int'(mem_rsp_tag));
                        void'(exp_q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_addr >= AW'(DEPTH)) begin
                    model_oob = 1'b1;
                    if (!mem_req_rw) begin
                        exp_q.push_back('{data: OOB, tag: mem_req_tag, acc: cyc + 1,
                                          exact: exp_q.size() == 0});
                        rd_accepts++;
                    end
                end else if (mem_req_rw) begin
                    for (int b = 0; b < BW; b++)
                        if (mem_req_byteen[b])
                            model_ram[mem_req_addr[5:0]][b*8 +: 8] = mem_req_data[b*8 +: 8];
                end else begin
                    exp_q.push_back('{data: model_ram[mem_req_addr[5:0]], tag: mem_req_tag,
                                      acc: cyc + 1, exact: exp_q.size() == 0});
                    rd_accepts++;
                end
            end
        end
    end

    // Issue one request from posedge+1, hold until accepted, return at posedge+1.
    task automatic req(input logic rw, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                       input logic [DW-1:0] data, input logic [TW-1:0] tag);
        int n;
        n = 0;
        mem_req_valid  = 1'b1;
        mem_req_rw     = rw;
        mem_req_addr   = addr;
        mem_req_byteen = be;
        mem_req_data   = data;
        mem_req_tag    = tag;
        @(negedge clk);
        while (!mem_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_int("req_accept", int'(mem_req_ready), 1);
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk_int("drain_outstanding", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int base;
        logic [AW-1:0] a;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic write then read-back with exact latency.
        rdy_mode = 1;
        req(1'b1, 3, '1, {16{32'h6F008004}}, 8'h00);
        req(1'b0, 3, '0, '0, 8'h05);
        drain();

        // Partial byte enables.
        req(1'b1, 7, '1, '1, 8'h00);
        req(1'b1, 7, 64'h0000_0000_0000_000F, '0, 8'h00);
        req(1'b0, 7, '0, '0, 8'h07);
        drain();

        // Backpressure: credit limit holds the fifth read until the consumer drains.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        pop_cyc.delete();
        pop_tag.delete();
        base = rd_accepts;
        fork
            begin
                for (int i = 0; i < 6; i++) req(1'b0, AW'(i), '0, '0, TW'(i));
            end
            begin
                repeat (15) @(posedge clk);
                #3;
                chk_int("bp_accepted", rd_accepts - base, 4);
                chk("bp_ready_low", DW'(mem_req_ready), '0);
                chk("bp_head_tag", DW'(mem_rsp_tag), '0);
                rdy_mode = 1;
            end
        join
        drain();
        chk_int("bp_pop_count", pop_tag.size(), 6);
        for (int i = 0; i < 6 && i < pop_tag.size(); i++) chk_int("bp_order", pop_tag[i], i);
        for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
            chk_int("bp_back_to_back", pop_cyc[i] - pop_cyc[0], i);

        // Out of bounds write/read; line 0 must remain untouched.
        req(1'b1, 64, '1, DW'(1), 8'h00);
        req(1'b0, 64, '0, '0, 8'hAA);
        req(1'b0, 0, '0, '0, 8'hAB);
        drain();

        // Randomized traffic with a random consumer.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                a = ($urandom_range(0, 9) != 0) ? AW'($urandom_range(0, 9))
                                                : AW'($urandom_range(60, 70));
                req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, rand_line(),
                    TW'($urandom));
            end
        end
        rdy_mode = 1;
        drain();

        // Reset mid-flight: in-flight reads vanish and RAM clears.
        req(1'b0, 1, '0, '0, 8'h21);
        req(1'b0, 2, '0, '0, 8'h22);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", DW'(mem_req_ready), '0);
        chk("midrst_rsp_valid", DW'(mem_rsp_valid), '0);
        chk("midrst_rsp_tag", DW'(mem_rsp_tag), '0);
        chk("midrst_busy", DW'(busy), '0);
        chk("midrst_oob_err", DW'(oob_err), '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        req(1'b0, 1, '0, '0, 8'h31);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
